// File: rtl/adt7310_pkg.sv
// Shared definitions for the ADT7310 one-shot measurement sequencer:
// FSM state encoding and the SPI command bytes sent to the sensor.
package adt7310_pkg;

  // Sensor command bytes (8-bit SPI frames)
  localparam logic [7:0] CMD_WR_CFG  = 8'h08;  // write configuration register
  localparam logic [7:0] CFG_ONESHOT = 8'h20;  // configuration value: one-shot mode
  localparam logic [7:0] CMD_RD_TEMP = 8'h50;  // read temperature register
  localparam logic [7:0] DUMMY       = 8'hFF;  // dummy byte to clock out read data

  typedef enum logic [3:0] {
    stIdle,
    stCfg2,
    stCfgWait,
    stCfgDrain,
    stConvWait,
    stRd2,
    stRd3,
    stRdWait,
    stRdCmd,
    stRdMSB,
    stRdLSB
  } state_t;

endpackage

// File: rtl/adt7310_conv_timer.sv
// Loadable down-counter used to wait out the sensor conversion time.
// Counts down to zero and stays there; Zero_o flags the terminal count.
module adt7310_conv_timer #(
  parameter int Width = 16
) (
  input  logic             Reset_n_i,
  input  logic             Clk_i,
  input  logic             Load_i,
  input  logic [Width-1:0] Preset_i,
  input  logic             Enable_i,
  output logic             Zero_o
);

  logic [Width-1:0] count;

  // Load has priority; decrement only while non-zero so the counter never wraps
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      count <= '0;
    end else if (Load_i) begin
      count <= Preset_i;
    end else if (Enable_i && (count != '0)) begin
      count <= count - Width'(1);
    end
  end

  assign Zero_o = (count == '0);

endmodule

// File: rtl/adt7310_measure_fsm.sv
// Runs one complete ADT7310 one-shot temperature measurement per Start_i
// pulse over the byte-oriented SPI master, then returns the two result bytes
// together with a one-cycle Done_o pulse.
module adt7310_measure_fsm
  import adt7310_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic                   Reset_n_i,
  input  logic                   Clk_i,
  input  logic                   Start_i,
  output logic                   Done_o,
  output logic [DataWidth-1:0]   Byte0_o,
  output logic [DataWidth-1:0]   Byte1_o,
  input  logic [2*DataWidth-1:0] ParamCounterPreset_i,
  output logic                   ADT7310CS_n_o,
  output logic [DataWidth-1:0]   SPI_Data_o,
  output logic                   SPI_Write_o,
  output logic                   SPI_ReadNext_o,
  input  logic [DataWidth-1:0]   SPI_Data_i,
  input  logic                   SPI_FIFOEmpty_i,
  input  logic                   SPI_Transmission_i
);

  state_t state;
  state_t nextState;

  logic busySeen;
  logic busySet;
  logic busyClear;
  logic timerLoad;
  logic timerEnable;
  logic timerZero;
  logic captureMsb;
  logic captureLsb;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state <= stIdle;
    end else begin
      state <= nextState;
    end
  end

  // Busy-seen flag: remembers that the SPI master actually started shifting,
  // so a late-rising Transmission cannot be mistaken for a finished transfer
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      busySeen <= 1'b0;
    end else if (busyClear) begin
      busySeen <= 1'b0;
    end else if (busySet) begin
      busySeen <= 1'b1;
    end
  end

  // Result bytes and the done pulse, which follows the LSB pop by one cycle
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      Done_o  <= 1'b0;
      Byte0_o <= '0;
      Byte1_o <= '0;
    end else begin
      Done_o <= captureLsb;
      if (captureMsb) begin
        Byte1_o <= SPI_Data_i;
      end
      if (captureLsb) begin
        Byte0_o <= SPI_Data_i;
      end
    end
  end

  adt7310_conv_timer #(
    .Width(2*DataWidth)
  ) convTimer (
    .Reset_n_i (Reset_n_i),
    .Clk_i     (Clk_i),
    .Load_i    (timerLoad),
    .Preset_i  (ParamCounterPreset_i),
    .Enable_i  (timerEnable),
    .Zero_o    (timerZero)
  );

  // Next-state and SPI strobe decode
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    nextState      = state;
    ADT7310CS_n_o  = 1'b1;
    SPI_Write_o    = 1'b0;
    SPI_ReadNext_o = 1'b0;
    SPI_Data_o     = '0;
    busySet        = 1'b0;
    busyClear      = 1'b0;
    timerLoad      = 1'b0;
    timerEnable    = 1'b0;
    captureMsb     = 1'b0;
    captureLsb     = 1'b0;

    case (state)
      stIdle: begin
        if (Start_i) begin
          ADT7310CS_n_o = 1'b0;
          SPI_Write_o   = 1'b1;
          SPI_Data_o    = DataWidth'(CMD_WR_CFG);
          nextState     = stCfg2;
        end
      end
      stCfg2: begin
        ADT7310CS_n_o = 1'b0;
        SPI_Write_o   = 1'b1;
        SPI_Data_o    = DataWidth'(CFG_ONESHOT);
        busyClear     = 1'b1;
        nextState     = stCfgWait;
      end
      stCfgWait: begin
        ADT7310CS_n_o = 1'b0;
        busySet       = SPI_Transmission_i;
        if (busySeen && !SPI_Transmission_i) begin
          nextState = stCfgDrain;
        end
      end
      stCfgDrain: begin
        // Bytes clocked in during the config write carry no information
        if (!SPI_FIFOEmpty_i) begin
          SPI_ReadNext_o = 1'b1;
        end else begin
          timerLoad = 1'b1;
          nextState = stConvWait;
        end
      end
      stConvWait: begin
        if (timerZero) begin
          ADT7310CS_n_o = 1'b0;
          SPI_Write_o   = 1'b1;
          SPI_Data_o    = DataWidth'(CMD_RD_TEMP);
          nextState     = stRd2;
        end else begin
          timerEnable = 1'b1;
        end
      end
      stRd2: begin
        ADT7310CS_n_o = 1'b0;
        SPI_Write_o   = 1'b1;
        SPI_Data_o    = DataWidth'(DUMMY);
        nextState     = stRd3;
      end
      stRd3: begin
        ADT7310CS_n_o = 1'b0;
        SPI_Write_o   = 1'b1;
        SPI_Data_o    = DataWidth'(DUMMY);
        busyClear     = 1'b1;
        nextState     = stRdWait;
      end
      stRdWait: begin
        ADT7310CS_n_o = 1'b0;
        busySet       = SPI_Transmission_i;
        if (busySeen && !SPI_Transmission_i) begin
          nextState = stRdCmd;
        end
      end
      stRdCmd: begin
        // First received byte answers the command frame and is discarded
        if (!SPI_FIFOEmpty_i) begin
          SPI_ReadNext_o = 1'b1;
          nextState      = stRdMSB;
        end
      end
      stRdMSB: begin
        if (!SPI_FIFOEmpty_i) begin
          SPI_ReadNext_o = 1'b1;
          captureMsb     = 1'b1;
          nextState      = stRdLSB;
        end
      end
      stRdLSB: begin
        if (!SPI_FIFOEmpty_i) begin
          SPI_ReadNext_o = 1'b1;
          captureLsb     = 1'b1;
          nextState      = stIdle;
        end
      end
      default: begin
        nextState = stIdle;
      end
    endcase
  end

endmodule
